// File: rtl/prio_enc_scan.sv
// rtl/prio_enc_scan.sv - registered priority encoder with hold capture, change counter and 2-digit 7-seg scan
module prio_enc_scan #(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 4,
    localparam int IDXW    = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            clr,
    input  logic [WIDTH-1:0] a,
    output logic            valid,
    output logic [IDXW-1:0] idx,
    output logic [7:0]      chg_cnt,
    output logic [6:0]      seg,
    output logic [1:0]      an
);

    localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic            comb_valid;
    logic [IDXW-1:0] comb_idx;
    logic            latch;
    logic            nxt_valid;
    logic [IDXW-1:0] nxt_idx;
    logic            nxt_latch;
    logic            changed;
    logic [CNTW-1:0] scan_cnt;
    logic            phase;
    logic            nxt_phase;
    logic [6:0]      idx_ext;
    logic [3:0]      tens;
    logic [3:0]      ones;
    logic [6:0]      nxt_seg;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Highest set bit wins: later iterations overwrite lower indices.
    always_comb begin
        comb_valid = |a;
        comb_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) comb_idx = IDXW'(i);
        end
    end

    // Select next valid/idx and latch state from enable, mode, latch and clear.
    always_comb begin
        nxt_valid = comb_valid;
        nxt_idx   = comb_idx;
        nxt_latch = 1'b0;
        if (!en) begin
            nxt_valid = 1'b0;
            nxt_idx   = '0;
        end else if (mode && latch && !clr) begin
            nxt_valid = valid;
            nxt_idx   = idx;
            nxt_latch = 1'b1;
        end else begin
            nxt_latch = mode && !clr && comb_valid;
        end
        changed = ({nxt_valid, nxt_idx} != {valid, idx});
    end

    // Encoder output, capture latch and saturating change counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            idx     <= '0;
            latch   <= 1'b0;
            chg_cnt <= 8'd0;
        end else begin
            valid <= nxt_valid;
            idx   <= nxt_idx;
            latch <= nxt_latch;
            if (clr)
                chg_cnt <= 8'd0;
            else if (changed && chg_cnt != 8'hFF)
                chg_cnt <= chg_cnt + 8'd1;
        end
    end

    // Decimal split and glyph selection for the phase the scan is about to enter,
    // so seg and an always move together.
    always_comb begin
        idx_ext   = 7'(idx);
        tens      = 4'(idx_ext / 7'd10);
        ones      = 4'(idx_ext % 7'd10);
        nxt_phase = (scan_cnt == CNTW'(SCAN_DIV - 1)) ? ~phase : phase;
        if (!en || !valid)
            nxt_seg = 7'b1111111;
        else if (nxt_phase)
            nxt_seg = (tens == 4'd0) ? 7'b1111111 : glyph(tens);
        else
            nxt_seg = glyph(ones);
    end

    // Scan divider, digit phase and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            phase    <= 1'b0;
            seg      <= 7'b1111111;
            an       <= 2'b11;
        end else begin
            scan_cnt <= (scan_cnt == CNTW'(SCAN_DIV - 1)) ? '0 : scan_cnt + CNTW'(1);
            phase    <= nxt_phase;
            seg      <= nxt_seg;
            an       <= en ? (nxt_phase ? 2'b01 : 2'b10) : 2'b11;
        end
    end

endmodule

// File: tb/tb_prio_enc_scan.sv
// tb/tb_prio_enc_scan.sv - directed self-checking bench for prio_enc_scan
module tb_prio_enc_scan;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;

    logic        clk = 1'b0;
    logic        rst, en, mode, clr;
    logic [15:0] a;
    logic [63:0] a64;
    logic [1:0]  a2;

    logic        valid, valid64, valid2;
    logic [3:0]  idx;
    logic [5:0]  idx64;
    logic        idx2;
    logic [7:0]  chg_cnt, chg64, chg2;
    logic [6:0]  seg, seg64, seg2;
    logic [1:0]  an, an64, an2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic ph;

    prio_enc_scan #(.WIDTH(16), .SCAN_DIV(4)) u16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .a(a),
        .valid(valid), .idx(idx), .chg_cnt(chg_cnt), .seg(seg), .an(an)
    );

    prio_enc_scan #(.WIDTH(64), .SCAN_DIV(4)) u64 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .a(a64),
        .valid(valid64), .idx(idx64), .chg_cnt(chg64), .seg(seg64), .an(an64)
    );

    prio_enc_scan #(.WIDTH(2), .SCAN_DIV(4)) u2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .a(a2),
        .valid(valid2), .idx(idx2), .chg_cnt(chg2), .seg(seg2), .an(an2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst) cyc = 0;
        else cyc = cyc + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; clr = 1'b0;
        a = 16'h0000; a64 = 64'h8000_0000_0000_0000; a2 = 2'b11;
        step(); step();
        chk("rst_valid", valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_chg", chg_cnt, 0);
        chk("rst_seg", seg, BLANK);
        chk("rst_an", an, 2'b11);

        // live encode
        rst = 1'b0; en = 1'b1;
        step();
        chk("live0_valid", valid, 0);
        chk("live0_idx", idx, 0);
        chk("live0_chg", chg_cnt, 0);
        a = 16'h0090; step();
        chk("live90_valid", valid, 1);
        chk("live90_idx", idx, 7);
        chk("live90_chg", chg_cnt, 1);
        a = 16'h8001; step();
        chk("live8001_idx", idx, 15);
        chk("live8001_chg", chg_cnt, 2);
        chk("w2_idx", idx2, 1);
        chk("w2_valid", valid2, 1);
        chk("w64_idx", idx64, 63);

        // hold capture
        mode = 1'b1; a = 16'h0008; step();
        chk("hold_cap_idx", idx, 3);
        chk("hold_cap_chg", chg_cnt, 3);
        a = 16'h4000; step();
        chk("hold_frz_idx", idx, 3);
        step();
        chk("hold_frz2_idx", idx, 3);
        chk("hold_frz_chg", chg_cnt, 3);
        clr = 1'b1; step();
        chk("hold_clr_idx", idx, 14);
        chk("hold_clr_chg", chg_cnt, 0);
        clr = 1'b0; step();
        chk("hold_relatch_idx", idx, 14);
        a = 16'h0001; step();
        chk("hold_latched_idx", idx, 14);
        chk("hold_latched_chg", chg_cnt, 0);
        mode = 1'b0; step();
        chk("mode_release_idx", idx, 0);
        chk("mode_release_valid", valid, 1);
        chk("mode_release_chg", chg_cnt, 1);

        // display scan with idx=12
        rst = 1'b1; step();
        rst = 1'b0; a = 16'h1000;
        for (int k = 0; k < 16; k++) begin
            step();
            ph = ((cyc / 4) % 2) == 1;
            chk("scan12_an", an, ph ? 2'b01 : 2'b10);
            chk("scan12_seg", seg, (cyc == 1) ? BLANK : (ph ? G1 : G2));
        end
        chk("scan12_idx", idx, 12);

        // idx=5: tens blank
        a = 16'h0020; step(); step();
        for (int k = 0; k < 8; k++) begin
            step();
            ph = ((cyc / 4) % 2) == 1;
            chk("scan5_an", an, ph ? 2'b01 : 2'b10);
            chk("scan5_seg", seg, ph ? BLANK : G5);
        end

        // saturation
        clr = 1'b1; a = 16'h0001; step();
        chk("sat_clr_chg", chg_cnt, 0);
        clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a = (i % 2 == 0) ? 16'h0002 : 16'h0001;
            step();
        end
        chk("sat_chg", chg_cnt, 255);
        a = (a == 16'h0001) ? 16'h0002 : 16'h0001; step();
        chk("sat_hold_chg", chg_cnt, 255);
        clr = 1'b1; a = 16'h0100; step();
        chk("sat_clr_change_chg", chg_cnt, 0);
        chk("sat_clr_change_idx", idx, 8);
        clr = 1'b0; step();
        chk("post_clr_chg", chg_cnt, 0);

        // enable low
        en = 1'b0; a = 16'hFFFF; step();
        chk("en0_valid", valid, 0);
        chk("en0_idx", idx, 0);
        chk("en0_seg", seg, BLANK);
        chk("en0_an", an, 2'b11);
        chk("en0_chg", chg_cnt, 1);
        step();
        chk("en0_chg_hold", chg_cnt, 1);

        // reset mid-hold clears latch
        en = 1'b1; mode = 1'b1; a = 16'h0008; step();
        chk("midhold_idx", idx, 3);
        rst = 1'b1; step();
        chk("midrst_valid", valid, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_chg", chg_cnt, 0);
        chk("midrst_seg", seg, BLANK);
        chk("midrst_an", an, 2'b11);
        rst = 1'b0; a = 16'h4000; step();
        chk("postrst_idx", idx, 14);

        // WIDTH=64 display alternates 3 and 6
        for (int k = 0; k < 8; k++) begin
            step();
            ph = ((cyc / 4) % 2) == 1;
            chk("w64_scan_idx", idx64, 63);
            chk("w64_scan_an", an64, ph ? 2'b01 : 2'b10);
            chk("w64_scan_seg", seg64, ph ? G6 : G3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
